// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the six-digit seven-segment scanner
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low seven-segment decoder
// Ports:
//   bcd - 4-bit BCD digit; codes 10-15 are not valid digits
//   seg - {g,f,e,d,c,b,a}, active-low; invalid codes show a dash
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed six-digit seven-segment scanner with anti-tearing shadow
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   s1,s2,m1,m2,h1,h2     - BCD time digits (slot 0 = s1 ... slot 5 = h2)
//   load                  - capture the six digits into the shadow register
//   colon_en              - enables the separator dots on slots 2 and 4
//   seg, dp               - active-low segments {g,f,e,d,c,b,a} and decimal point
//   an                    - active-low one-hot digit enables
//   frame_done            - one-cycle pulse after the scan wraps from slot 5 to slot 0
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    input  logic       load,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_done
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;       // slot that the next tick will display
    logic [2:0]       slot;      // slot currently on the display
    logic             blank_q;   // high during the ghost-blanking cycle
    logic [3:0]       shadow [NUM_DIGITS];
    logic [3:0]       active [NUM_DIGITS];

    logic       tick;
    logic       wrap;
    logic [3:0] cur_digit;
    logic [6:0] dec_seg;

    assign tick      = (cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap      = tick && (idx == 3'(NUM_DIGITS - 1));
    assign cur_digit = active[idx];

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // seg/dp are registered on the tick edge from the pre-copy active value,
    // so h2 of the ending frame is still shown from the old snapshot while
    // the new snapshot is taken for the frame that starts at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            slot       <= '0;
            blank_q    <= 1'b0;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= 6'b111111;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            frame_done <= wrap;
            cnt        <= tick ? '0 : cnt + CNT_W'(1);

            if (load) begin
                shadow[0] <= s1;
                shadow[1] <= s2;
                shadow[2] <= m1;
                shadow[3] <= m2;
                shadow[4] <= h1;
                shadow[5] <= h2;
            end

            if (wrap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
            end

            if (tick) begin
                idx     <= wrap ? 3'd0 : idx + 3'd1;
                slot    <= idx;
                blank_q <= 1'b1;
                an      <= 6'b111111;
                if (BLANK_LEADING && (idx == 3'd5) && (cur_digit == 4'd0)) begin
                    seg <= SEG_BLANK;
                end else begin
                    seg <= dec_seg;
                end
                dp <= ~(colon_en && ((idx == 3'd2) || (idx == 3'd4)));
            end else begin
                blank_q <= 1'b0;
                if (blank_q) begin
                    an <= ~(6'd1 << slot);
                end
            end
        end
    end

endmodule
